// File: rtl/vid_timing_pkg.sv
// Raster timing constants for the video sync generator: PAL/NTSC line and field
// lengths, sync/blank placement, and the counter widths shared by the raster logic.
package vid_timing_pkg;

   localparam int DOT_W  = 12;
   localparam int LINE_W = 10;

   localparam int HT_PAL   = 2016;
   localparam int HT_NTSC  = 2080;
   localparam int VT_PAL   = 312;
   localparam int VT_NTSC  = 263;
   localparam int HS_START = 64;
   localparam int HS_LEN   = 152;
   localparam int HB_START = 1950;
   localparam int HB_END   = 260;
   localparam int VS_LINES = 3;
   localparam int VB_START = 6;
   localparam int VB_LINES = 24;

   typedef struct packed {
      logic [DOT_W-1:0]  ht;
      logic [LINE_W-1:0] vt;
   } timing_t;

   function automatic timing_t make_timing(input int ht, input int vt);
      timing_t t;
      t.ht = DOT_W'(ht);
      t.vt = LINE_W'(vt);
      return t;
   endfunction

endpackage

// File: rtl/vid_sync_gen.sv
// Raster timing generator: free-running dot/line counters with registered
// hsync/vsync, hblank/vblank, field and frame_start, PAL/NTSC, progressive or 2:1 interlace.
module vid_sync_gen
   import vid_timing_pkg::*;
#(
   parameter int PAL_HT       = HT_PAL,
   parameter int NTSC_HT      = HT_NTSC,
   parameter int PAL_VT       = VT_PAL,
   parameter int NTSC_VT      = VT_NTSC,
   parameter int HSYNC_START  = HS_START,
   parameter int HSYNC_LEN    = HS_LEN,
   parameter int HBLANK_START = HB_START,
   parameter int HBLANK_END   = HB_END,
   parameter int VSYNC_LINES  = VS_LINES,
   parameter int VBLANK_LEAD  = VB_START,
   parameter int VBLANK_LINES = VB_LINES
) (
   input  logic              clk32,
   input  logic              reset,
   input  logic              pause,
   input  logic              pal,
   input  logic              ilace_en,
   output logic              hsync,
   output logic              vsync,
   output logic              hblank,
   output logic              vblank,
   output logic              field,
   output logic [DOT_W-1:0]  dot,
   output logic [LINE_W-1:0] line,
   output logic              frame_start
);

   localparam timing_t           TM_PAL    = make_timing(PAL_HT, PAL_VT);
   localparam timing_t           TM_NTSC   = make_timing(NTSC_HT, NTSC_VT);
   localparam logic [DOT_W-1:0]  HS_ON     = DOT_W'(HSYNC_START);
   localparam logic [DOT_W-1:0]  HS_OFF    = DOT_W'(HSYNC_START + HSYNC_LEN);
   localparam logic [DOT_W-1:0]  HB_ON     = DOT_W'(HBLANK_START);
   localparam logic [DOT_W-1:0]  HB_OFF    = DOT_W'(HBLANK_END);
   localparam logic [LINE_W-1:0] VS_RELOAD = LINE_W'(VSYNC_LINES - 1);
   localparam logic [LINE_W-1:0] VB_RELOAD = LINE_W'(VBLANK_LINES - 1);
   localparam logic [LINE_W-1:0] VB_LEAD   = LINE_W'(VBLANK_LEAD);

   logic              pal_r;
   logic              ilace_r;
   logic              odd;
   logic              dot_end;
   logic              line_end;
   logic              field_nxt;
   timing_t           tm;
   logic [LINE_W-1:0] vt_field;
   logic [LINE_W-1:0] vsync_cnt;
   logic [LINE_W-1:0] vblank_cnt;
   logic [DOT_W-1:0]  vd_sum;
   logic [DOT_W-1:0]  vd_dot;

   // Field 1 of an interlaced frame is one line short and starts vsync mid-line.
   always_comb begin
      tm        = pal_r ? TM_PAL : TM_NTSC;
      odd       = field & ilace_r;
      vt_field  = odd ? tm.vt - LINE_W'(1) : tm.vt;
      dot_end   = (dot == tm.ht - DOT_W'(1));
      line_end  = (line == vt_field - LINE_W'(1));
      field_nxt = ilace_en & ~field;
      vd_sum    = HS_ON + {1'b0, tm.ht[DOT_W-1:1]};
      vd_dot    = HS_ON;
      if (odd)
         vd_dot = (vd_sum >= tm.ht) ? vd_sum - tm.ht : vd_sum;
   end

   always_ff @(posedge clk32) begin
      if (reset) begin
         dot         <= '0;
         line        <= '0;
         field       <= 1'b0;
         pal_r       <= pal;
         ilace_r     <= ilace_en;
         frame_start <= 1'b0;
      end else if (pause) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (dot_end) begin
            dot <= '0;
            if (line_end) begin
               line    <= '0;
               ilace_r <= ilace_en;
               field   <= field_nxt;
               // Standard changes only on a frame boundary, never between interlaced fields.
               if (!field_nxt) begin
                  pal_r       <= pal;
                  frame_start <= 1'b1;
               end
            end else begin
               line <= line + LINE_W'(1);
            end
         end else begin
            dot <= dot + DOT_W'(1);
         end
      end
   end

   always_ff @(posedge clk32) begin
      if (reset) begin
         hsync  <= 1'b0;
         hblank <= 1'b0;
      end else if (!pause) begin
         hsync  <= (dot >= HS_ON) && (dot < HS_OFF);
         hblank <= (dot >= HB_ON) || (dot < HB_OFF);
      end
   end

   // Line down-counters are stepped once per line at the sync dot, so blanking
   // started near the end of a field carries over into the next one.
   always_ff @(posedge clk32) begin
      if (reset) begin
         vsync      <= 1'b0;
         vblank     <= 1'b0;
         vsync_cnt  <= '0;
         vblank_cnt <= '0;
      end else if (!pause) begin
         if (dot == vd_dot) begin
            if (line == '0) begin
               vsync     <= 1'b1;
               vsync_cnt <= VS_RELOAD;
            end else if (vsync_cnt != '0) begin
               vsync_cnt <= vsync_cnt - LINE_W'(1);
            end else begin
               vsync <= 1'b0;
            end
         end
         if (dot == HS_ON) begin
            if (line == vt_field - VB_LEAD) begin
               vblank     <= 1'b1;
               vblank_cnt <= VB_RELOAD;
            end else if (vblank_cnt != '0) begin
               vblank_cnt <= vblank_cnt - LINE_W'(1);
            end else begin
               vblank <= 1'b0;
            end
         end
      end
   end

endmodule
